// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared types and constants for the multiplexed 7-segment
//                display driver: segment pattern type, the all-off pattern,
//                glyph-set selectors and the two glyph lookup tables.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Segment bit order is {DP,G,F,E,D,C,B,A}, active low (0 = segment lit).
//  Every table entry has DP off (bit 7 = 1); the driver ANDs the decimal
//  point in afterwards.
// ============================================================================
package seg7_pkg;

  typedef logic [7:0] seg_t;

  localparam seg_t SEG_OFF = 8'hFF;

  localparam int GLYPH_HEX    = 0;
  localparam int GLYPH_LEGACY = 1;

  // Entry [n] is the glyph for nibble n (listed F down to 0).
  localparam logic [15:0][7:0] c_hex_glyphs = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  // Legacy set: digits as hex, A=blank, B=P, C=L, D=E, E=S, F=F.
  localparam logic [15:0][7:0] c_legacy_glyphs = {
    8'h8E, 8'h92, 8'h86, 8'hC7, 8'h8C, 8'hFF, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic seg_t glyph_lookup(input logic [3:0] nibble,
                                        input logic       legacy);
    return legacy ? c_legacy_glyphs[nibble] : c_hex_glyphs[nibble];
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_glyph_decode.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_glyph_decode
//  Description : Purely combinational nibble-to-segment decoder with a
//                selectable glyph set.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    i_nibble  in  4  value to display
//    i_legacy  in  1  0 = hex glyphs, 1 = legacy glyph set
//    o_seg     out 8  active-low {DP,G,F,E,D,C,B,A}, DP always off
// ============================================================================
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_legacy,
  output seg_t       o_seg
);

  assign o_seg = glyph_lookup(i_nibble, i_legacy);

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_driver
//  Description : Multiplexed NUM_DIGITS-digit 7-segment driver. A packed
//                nibble word is accepted over valid/ready into a shadow
//                register and committed to the displayed (active) word only
//                at frame boundaries, so a frame never shows mixed words.
//                Digits share one active-low segment bus, with per-digit
//                anode strobes, a blanking gap at the start of every digit
//                slot, optional leading-zero blanking and two glyph sets.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Build option
//    SEG7_BLINK_EN  adds i_blink_mask and BLINK_FRAMES; masked digits go dark
//                   during alternate runs of BLINK_FRAMES frames.
//  Ports
//    clk            in  1              system clock
//    rst            in  1              asynchronous active-high reset
//    i_load_valid   in  1              new display word offered
//    o_load_ready   out 1              shadow slot free
//    i_load_value   in  4*NUM_DIGITS   packed nibbles, digit 0 = [3:0]
//    i_load_dp      in  NUM_DIGITS     decimal point per digit, 1 = lit
//    i_load_lzb     in  1              leading-zero blanking for this word
//    i_blink_mask   in  NUM_DIGITS     (SEG7_BLINK_EN only) digits to blink
//    o_seg_n        out 8              {DP,G,F,E,D,C,B,A}, 0 = lit
//    o_an_n         out NUM_DIGITS     anode strobes, 0 = enabled
//    o_frame_tick   out 1              pulse in the frame-boundary cycle
// ============================================================================
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 6,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int GLYPH_MODE   = 0
`ifdef SEG7_BLINK_EN
  ,
  parameter int BLINK_FRAMES = 32
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_load_valid,
  output logic                    o_load_ready,
  input  logic [4*NUM_DIGITS-1:0] i_load_value,
  input  logic [NUM_DIGITS-1:0]   i_load_dp,
  input  logic                    i_load_lzb,
`ifdef SEG7_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   i_blink_mask,
`endif
  output seg_t                    o_seg_n,
  output logic [NUM_DIGITS-1:0]   o_an_n,
  output logic                    o_frame_tick
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] c_cnt_last  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] c_blank_end = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] c_idx_last  = IDX_W'(NUM_DIGITS - 1);
  localparam logic             c_legacy    = (GLYPH_MODE == GLYPH_LEGACY);

  // --------------------------------------------------------------------------
  // Scan state
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;

  logic w_cnt_wrap;
  logic w_frame;

  assign w_cnt_wrap = (r_cnt == c_cnt_last);
  assign w_frame    = w_cnt_wrap && (r_idx == c_idx_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_cnt_wrap) begin
      r_cnt <= '0;
      r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + IDX_W'(1);
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Load handshake: shadow register plus active (displayed) word
  // --------------------------------------------------------------------------
  logic                    r_pending;
  logic [4*NUM_DIGITS-1:0] r_sh_value;
  logic [NUM_DIGITS-1:0]   r_sh_dp;
  logic                    r_sh_lzb;
  logic [4*NUM_DIGITS-1:0] r_act_value;
  logic [NUM_DIGITS-1:0]   r_act_dp;
  logic                    r_act_lzb;

  logic w_accept;

  assign w_accept = i_load_valid && !r_pending;

  // Accept only happens with pending clear and commit only with pending set,
  // so a word accepted in a boundary cycle waits for the next boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending   <= 1'b0;
      r_sh_value  <= '0;
      r_sh_dp     <= '0;
      r_sh_lzb    <= 1'b0;
      r_act_value <= '0;
      r_act_dp    <= '0;
      r_act_lzb   <= 1'b0;
    end else begin
      if (w_frame && r_pending) begin
        r_act_value <= r_sh_value;
        r_act_dp    <= r_sh_dp;
        r_act_lzb   <= r_sh_lzb;
      end
      if (w_accept) begin
        r_sh_value <= i_load_value;
        r_sh_dp    <= i_load_dp;
        r_sh_lzb   <= i_load_lzb;
        r_pending  <= 1'b1;
      end else if (w_frame) begin
        r_pending  <= 1'b0;
      end
    end
  end

  assign o_load_ready = !r_pending;
  assign o_frame_tick = w_frame;

  // --------------------------------------------------------------------------
  // Current-digit selection and leading-zero detection
  // --------------------------------------------------------------------------
  logic [3:0]            w_nibble;
  logic                  w_dp_sel;
  logic                  w_lz_sel;
  logic [NUM_DIGITS-1:0] w_onehot;

  // Walking from the top digit down, v_zero_above stays set while every
  // nibble at or above the current position is zero; such a digit is a
  // leading zero unless it is digit 0.
  always_comb begin : p_digit_sel
    logic v_zero_above;
    w_nibble     = 4'h0;
    w_dp_sel     = 1'b0;
    w_lz_sel     = 1'b0;
    w_onehot     = '0;
    v_zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      v_zero_above = v_zero_above && (r_act_value[4*i +: 4] == 4'h0);
      if (r_idx == IDX_W'(i)) begin
        w_nibble    = r_act_value[4*i +: 4];
        w_dp_sel    = r_act_dp[i];
        w_lz_sel    = v_zero_above && (i != 0);
        w_onehot[i] = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Blink phase
  // --------------------------------------------------------------------------
  logic w_blink_off;

`ifdef SEG7_BLINK_EN
  localparam int BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BF_W-1:0] r_blink_cnt;
  logic            r_blink_phase;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (w_frame) begin
      if (r_blink_cnt == BF_W'(BLINK_FRAMES - 1)) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= !r_blink_phase;
      end else begin
        r_blink_cnt   <= r_blink_cnt + BF_W'(1);
      end
    end
  end

  assign w_blink_off = r_blink_phase && |(i_blink_mask & w_onehot);
`else
  assign w_blink_off = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Glyph decode and registered outputs
  // --------------------------------------------------------------------------
  seg_t w_glyph;
  logic w_in_gap;
  logic w_dark;

  seg7_glyph_decode u_glyph (
    .i_nibble (w_nibble),
    .i_legacy (c_legacy),
    .o_seg    (w_glyph)
  );

  assign w_in_gap = (r_cnt < c_blank_end);
  assign w_dark   = (r_act_lzb && w_lz_sel) || w_blink_off;

  seg_t                  r_seg_n;
  logic [NUM_DIGITS-1:0] r_an_n;

  // Table glyphs carry DP off, so clearing bit 7 lights the decimal point.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg_n <= SEG_OFF;
      r_an_n  <= '1;
    end else if (w_in_gap) begin
      r_seg_n <= SEG_OFF;
      r_an_n  <= '1;
    end else begin
      r_an_n  <= ~w_onehot;
      r_seg_n <= w_dark ? SEG_OFF : (w_glyph & {!w_dp_sel, 7'h7F});
    end
  end

  assign o_seg_n = r_seg_n;
  assign o_an_n  = r_an_n;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_scan_driver
//  Description : Self-checking bench for seg7_scan_driver. Two instances
//                (hex and legacy glyph sets) share one stimulus stream; the
//                expected outputs come from a frame/slot model computed from
//                the cycle count since reset. With SEG7_BLINK_EN defined the
//                blink behaviour is exercised as well.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_seg7_scan_driver;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int BL = 1;
  localparam int BF = 2;
  localparam int FR = SD * ND;

  logic        clk;
  logic        rst;
  logic        load_valid;
  logic [15:0] load_value;
  logic [3:0]  load_dp;
  logic        load_lzb;
  logic [3:0]  blink_mask;

  logic       rdy_h, rdy_l, tick_h, tick_l;
  logic [7:0] seg_h, seg_l;
  logic [3:0] an_h, an_l;

  int vectors     = 0;
  int miscompares = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  seg7_scan_driver #(
    .NUM_DIGITS   (ND),
    .SCAN_DIV     (SD),
    .BLANK_CYCLES (BL),
    .GLYPH_MODE   (0)
`ifdef SEG7_BLINK_EN
    ,
    .BLINK_FRAMES (BF)
`endif
  ) u_dut_hex (
    .clk          (clk),
    .rst          (rst),
    .i_load_valid (load_valid),
    .o_load_ready (rdy_h),
    .i_load_value (load_value),
    .i_load_dp    (load_dp),
    .i_load_lzb   (load_lzb),
`ifdef SEG7_BLINK_EN
    .i_blink_mask (blink_mask),
`endif
    .o_seg_n      (seg_h),
    .o_an_n       (an_h),
    .o_frame_tick (tick_h)
  );

  seg7_scan_driver #(
    .NUM_DIGITS   (ND),
    .SCAN_DIV     (SD),
    .BLANK_CYCLES (BL),
    .GLYPH_MODE   (1)
`ifdef SEG7_BLINK_EN
    ,
    .BLINK_FRAMES (BF)
`endif
  ) u_dut_leg (
    .clk          (clk),
    .rst          (rst),
    .i_load_valid (load_valid),
    .o_load_ready (rdy_l),
    .i_load_value (load_value),
    .i_load_dp    (load_dp),
    .i_load_lzb   (load_lzb),
`ifdef SEG7_BLINK_EN
    .i_blink_mask (blink_mask),
`endif
    .o_seg_n      (seg_l),
    .o_an_n       (an_l),
    .o_frame_tick (tick_l)
  );

  // Reference glyph tables, DP off.
  logic [7:0] hex_t [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [7:0] leg_t [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'hFF, 8'h8C, 8'hC7, 8'h86, 8'h92, 8'h8E};

  // Reference model state. n = clock edges since reset release.
  int          n;
  bit          m_pending;
  bit          m_accepted;
  logic [15:0] m_sh_val, m_act_val, m_prev_val;
  logic [3:0]  m_sh_dp, m_act_dp, m_prev_dp;
  bit          m_sh_lzb, m_act_lzb, m_prev_lzb;
  logic [3:0]  m_mask_prev;

  function automatic bit exp_tick(input int k);
    return (k % FR) == (FR - 1);
  endfunction

  // Expected segment bus for the scan position s edges after reset.
  function automatic logic [7:0] exp_seg(input int s, input bit legacy);
    int         c, d;
    logic [3:0] nib;
    logic [3:0] msk;
    logic [7:0] g;
    if (s < 0) return 8'hFF;
    c = s % SD;
    d = (s / SD) % ND;
    if (c < BL) return 8'hFF;
    nib = 4'((m_prev_val >> (4 * d)) & 16'hF);
    if (m_prev_lzb && d != 0 && (m_prev_val >> (4 * d)) == 16'h0) return 8'hFF;
    msk = m_mask_prev;
`ifndef SEG7_BLINK_EN
    msk = 4'h0;
`endif
    if (msk[d] && (((s / FR) / BF) % 2 == 1)) return 8'hFF;
    g    = legacy ? leg_t[nib] : hex_t[nib];
    g[7] = ~m_prev_dp[d];
    return g;
  endfunction

  function automatic logic [3:0] exp_an(input int s);
    int d;
    if (s < 0 || (s % SD) < BL) return 4'hF;
    d = (s / SD) % ND;
    return ~(4'b0001 << d);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, n);
    end
  endtask

  task automatic check_outputs();
    int s;
    s = n - 1;
    chk("seg_hex",  seg_h, exp_seg(s, 1'b0));
    chk("seg_leg",  seg_l, exp_seg(s, 1'b1));
    chk("an_hex",   {4'h0, an_h}, {4'h0, exp_an(s)});
    chk("an_leg",   {4'h0, an_l}, {4'h0, exp_an(s)});
    chk("ready_hex", {7'h0, rdy_h}, {7'h0, !m_pending});
    chk("ready_leg", {7'h0, rdy_l}, {7'h0, !m_pending});
    chk("tick_hex", {7'h0, tick_h}, {7'h0, exp_tick(n)});
    chk("tick_leg", {7'h0, tick_l}, {7'h0, exp_tick(n)});
  endtask

  // One clock: apply the frame/handshake rules at the edge, then check.
  task automatic step();
    bit          tick_pre, acc;
    logic [15:0] v;
    logic [3:0]  dp, msk;
    bit          lzb;
    tick_pre = exp_tick(n);
    acc      = load_valid && !m_pending;
    v = load_value; dp = load_dp; lzb = load_lzb; msk = blink_mask;
    @(posedge clk);
    m_prev_val  = m_act_val;
    m_prev_dp   = m_act_dp;
    m_prev_lzb  = m_act_lzb;
    m_mask_prev = msk;
    if (tick_pre && m_pending) begin
      m_act_val = m_sh_val; m_act_dp = m_sh_dp; m_act_lzb = m_sh_lzb;
      m_pending = 1'b0;
    end
    if (acc) begin
      m_sh_val = v; m_sh_dp = dp; m_sh_lzb = lzb;
      m_pending = 1'b1;
    end
    m_accepted = acc;
    n++;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  // Called at a falling edge: reset asynchronously mid-cycle, check the
  // outputs react at once, release at the following falling edge.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_seg", seg_h, 8'hFF);
    chk("rst_an", {4'h0, an_h}, 8'h0F);
    chk("rst_ready", {7'h0, rdy_h}, 8'h01);
    chk("rst_tick", {7'h0, tick_h}, 8'h00);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    m_pending = 1'b0; m_accepted = 1'b0;
    m_sh_val = '0; m_sh_dp = '0; m_sh_lzb = 1'b0;
    m_act_val = '0; m_act_dp = '0; m_act_lzb = 1'b0;
    m_prev_val = '0; m_prev_dp = '0; m_prev_lzb = 1'b0;
    m_mask_prev = '0;
    check_outputs();
  endtask

  // Offer a word and hold it until accepted, within a cycle budget.
  task automatic load_word(input logic [15:0] v, input logic [3:0] dp, input bit lzb);
    load_valid = 1'b1; load_value = v; load_dp = dp; load_lzb = lzb;
    m_accepted = 1'b0;
    for (int k = 0; k < 3 * FR && !m_accepted; k++) step();
    chk("load_accept", {7'h0, m_accepted}, 8'h01);
    load_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    load_valid = 1'b0; load_value = '0; load_dp = '0; load_lzb = 1'b0;
    blink_mask = '0;
    n = 0;
    @(negedge clk);
    do_reset();

    // Idle display of zero, then reset in the middle of a scan.
    run(2 * FR);
    run(6);
    do_reset();

    // First word mid-frame, second word offered straight after.
    run(5);
    load_word(16'h1234, 4'b0000, 1'b0);
    load_word(16'h5678, 4'b1010, 1'b0);
    run(3 * FR);

    // Leading-zero blanking with a decimal point on digit 0.
    load_word(16'h0050, 4'b0001, 1'b1);
    run(2 * FR);

    // Nibbles whose glyphs differ between the two sets.
    load_word(16'hBA0B, 4'b0000, 1'b0);
    run(2 * FR);
    load_word(16'h000A, 4'b0100, 1'b1);
    run(2 * FR);

    // Blink digit 0 over several phase periods.
    blink_mask = 4'b0001;
    load_word(16'h0000, 4'b0000, 1'b0);
    run(6 * FR);
    blink_mask = 4'b0000;

    // Randomized traffic with a reset part-way through.
    for (int it = 0; it < 600; it++) begin
      if (!load_valid || m_accepted) begin
        load_valid = ($urandom_range(0, 3) == 0);
        for (int j = 0; j < 4; j++)
          load_value[4*j +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
        load_dp  = 4'($urandom);
        load_lzb = 1'($urandom);
      end
      if ($urandom_range(0, 31) == 0) blink_mask = 4'($urandom);
      step();
      if (it == 300) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
